// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: program counter, program memory read port,
// flush, and the instruction handshake toward decode.
interface instruction_fetch_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] pc_value;
   logic              pc_enable;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_req;
   logic              mem_ack;
   logic [7:0]        mem_data;
   logic              flush;
   logic              instr_valid;
   logic              instr_ready;
   logic [7:0]        opcode;
   logic [15:0]       operand;
   logic [1:0]        instr_len;
   logic [ADDR_W-1:0] instr_addr;

   modport master (
      input  pc_value,
      input  mem_ack,
      input  mem_data,
      input  flush,
      input  instr_ready,
      output pc_enable,
      output mem_addr,
      output mem_req,
      output instr_valid,
      output opcode,
      output operand,
      output instr_len,
      output instr_addr
   );

   modport slave (
      output pc_value,
      output mem_ack,
      output mem_data,
      output flush,
      output instr_ready,
      input  pc_enable,
      input  mem_addr,
      input  mem_req,
      input  instr_valid,
      input  opcode,
      input  operand,
      input  instr_len,
      input  instr_addr
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads 1-3 bytes per instruction, pulses the PC
// once per byte, and presents the instruction over valid/ready.
module instruction_fetch #(
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_STEP,
      S_HOLD
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_cnt;
   logic [7:0]        r_opcode;
   logic [15:0]       r_operand;
   logic [1:0]        r_len;
   logic [ADDR_W-1:0] r_addr;
   logic              r_pc_en;
   logic              r_valid;
   logic              w_mem_req;
   logic [ADDR_W-1:0] w_mem_addr;
   logic              w_take;

   function automatic logic [1:0] len_decode(input logic [7:0] op);
      logic [1:0] len;
      unique case (op[7:6])
         2'b00:   len = 2'd1;
         2'b01:   len = 2'd2;
         default: len = 2'd3;
      endcase
      return len;
   endfunction

   assign w_take = (r_state == S_FETCH) && bus.mem_ack && !bus.flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc_en <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         r_pc_en <= (w_next == S_STEP);
         r_valid <= (w_next == S_HOLD);
      end
   end

   always_comb begin
      w_next     = r_state;
      w_mem_req  = 1'b0;
      w_mem_addr = '0;
      unique case (r_state)
         S_IDLE:  w_next = S_FETCH;
         S_FETCH: begin
            w_mem_req  = 1'b1;
            w_mem_addr = bus.pc_value;
            if (bus.mem_ack)
               w_next = S_STEP;
         end
         S_STEP: begin
            if (r_cnt < r_len)
               w_next = S_FETCH;
            else
               w_next = S_HOLD;
         end
         S_HOLD: begin
            if (r_valid && bus.instr_ready)
               w_next = S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
      if (bus.flush)
         w_next = S_IDLE;
   end

   // Slot index r_cnt selects which byte the acknowledged data lands in
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_opcode  <= '0;
         r_operand <= '0;
         r_len     <= '0;
         r_addr    <= '0;
      end else if (bus.flush) begin
         r_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: r_cnt <= '0;
            S_FETCH: begin
               if (r_cnt == 2'd0)
                  r_addr <= bus.pc_value;
               if (w_take) begin
                  r_cnt <= r_cnt + 2'd1;
                  unique case (r_cnt)
                     2'd0: begin
                        r_opcode  <= bus.mem_data;
                        r_len     <= len_decode(bus.mem_data);
                        r_operand <= '0;
                     end
                     2'd1:    r_operand[7:0]  <= bus.mem_data;
                     default: r_operand[15:8] <= bus.mem_data;
                  endcase
               end
            end
            S_HOLD: begin
               if (r_valid && bus.instr_ready)
                  r_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req     = w_mem_req;
   assign bus.mem_addr    = w_mem_addr;
   assign bus.pc_enable   = r_pc_en & ~bus.flush;
   assign bus.instr_valid = r_valid & ~bus.flush;
   assign bus.opcode      = r_opcode;
   assign bus.operand     = r_operand;
   assign bus.instr_len   = r_len;
   assign bus.instr_addr  = r_addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory/PC responder, per-cycle
// instruction scoreboard, and directed scenarios.
module tb_instruction_fetch;
   localparam int AW = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instruction_fetch_if #(.ADDR_W(AW)) bus();

   instruction_fetch #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]    mem [0:4095];
   logic [AW-1:0] pcv;
   logic [AW-1:0] reload;
   int            wait_n;
   int            waitc;
   int            npulse;
   int            nvec;
   int            nerr;
   int            n;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!bus.instr_valid && cnt < 200) begin
         step();
         cnt++;
      end
      if (!bus.instr_valid) begin
         nvec++;
         nerr++;
         $display("FAIL wait_valid: got timeout expected instr_valid");
      end
   endtask

   // Program counter and program memory responder
   initial begin
      logic s_en, s_fl, s_req, s_ack;
      waitc = 0;
      forever begin
         @(negedge clk);
         s_en  = bus.pc_enable;
         s_fl  = bus.flush;
         s_req = bus.mem_req;
         s_ack = bus.mem_ack;
         if (s_en) npulse++;
         @(posedge clk);
         #1;
         if (s_fl) pcv = reload;
         else if (s_en) pcv = pcv + 1'b1;
         bus.pc_value = pcv;
         #1;
         if (s_req && !s_ack) waitc++;
         else waitc = 0;
         bus.mem_ack  = bus.mem_req && (waitc >= wait_n);
         bus.mem_data = mem[bus.mem_addr];
      end
   end

   // Scoreboard: what the next instruction must be, from memory contents
   initial begin
      logic [AW-1:0] exp_addr, a1, a2;
      logic [7:0]    op, b1, b2;
      int            ln, pulses;
      exp_addr = '0;
      pulses   = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_addr = bus.pc_value;
            pulses   = 0;
         end else begin
            if (bus.mem_req)
               chk("sb_mem_addr", bus.mem_addr, bus.pc_value);
            if (bus.flush) begin
               chk("sb_flush_pc_en", bus.pc_enable, 0);
               chk("sb_flush_valid", bus.instr_valid, 0);
            end
            if (bus.instr_valid) begin
               op = mem[exp_addr];
               ln = (op[7:6] == 2'b00) ? 1 : (op[7:6] == 2'b01) ? 2 : 3;
               a1 = exp_addr + 1'b1;
               a2 = exp_addr + 2'd2;
               b1 = (ln > 1) ? mem[a1] : 8'h00;
               b2 = (ln > 2) ? mem[a2] : 8'h00;
               chk("sb_opcode", bus.opcode, op);
               chk("sb_operand", bus.operand, {b2, b1});
               chk("sb_len", bus.instr_len, ln);
               chk("sb_addr", bus.instr_addr, exp_addr);
               chk("sb_pc", bus.pc_value, exp_addr + AW'(ln));
               chk("sb_pulses", pulses, ln);
               if (bus.instr_ready) begin
                  exp_addr = exp_addr + AW'(ln);
                  pulses   = 0;
               end
            end
            if (bus.pc_enable) pulses++;
            if (bus.flush) begin
               exp_addr = reload;
               pulses   = 0;
            end
         end
      end
   end

   initial begin
      nvec = 0;
      nerr = 0;
      npulse = 0;
      reset = 1'b1;
      pcv = '0;
      reload = '0;
      wait_n = 5;
      bus.pc_value = '0;
      bus.mem_ack = 1'b0;
      bus.mem_data = '0;
      bus.flush = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h000] = 8'h12;
      mem[12'h0A0] = 8'h85;
      mem[12'h0A1] = 8'h34;
      mem[12'h0A2] = 8'h12;
      mem[12'h0B0] = 8'h41;
      mem[12'h0B1] = 8'h99;
      mem[12'hFFF] = 8'h40;

      // Reset asserted mid-fetch
      repeat (2) step();
      reset = 1'b0;
      step();
      chk("first_fetch_req", bus.mem_req, 1);
      step();
      reset = 1'b1;
      #1;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_pc_en", bus.pc_enable, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_opcode", bus.opcode, 0);
      chk("rst_operand", bus.operand, 0);
      chk("rst_len", bus.instr_len, 0);
      chk("rst_addr", bus.instr_addr, 0);
      step();
      reset = 1'b0;
      wait_n = 0;
      #1;
      chk("idle_req", bus.mem_req, 0);
      step();
      chk("post_rst_req", bus.mem_req, 1);
      chk("post_rst_addr", bus.mem_addr, 0);

      // 1-byte instruction, zero-wait
      npulse = 0;
      wait_valid(n);
      chk("b1_latency", n, 2);
      chk("b1_opcode", bus.opcode, 8'h12);
      chk("b1_operand", bus.operand, 16'h0000);
      chk("b1_len", bus.instr_len, 1);
      chk("b1_addr", bus.instr_addr, 12'h000);
      chk("b1_pc", bus.pc_value, 12'h001);
      chk("b1_pulses", npulse, 1);

      // Back-pressure
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", bus.instr_valid, 1);
         chk("bp_opcode", bus.opcode, 8'h12);
         chk("bp_req", bus.mem_req, 0);
         chk("bp_pc_en", bus.pc_enable, 0);
      end
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      chk("bp_fetch_req", bus.mem_req, 1);
      chk("bp_fetch_addr", bus.mem_addr, 12'h001);
      wait_valid(n);
      chk("bp_next_lat", n, 2);

      // Flush from HOLD into a 3-byte instruction with 2 wait states
      reload = 12'h0A0;
      bus.flush = 1'b1;
      bus.instr_ready = 1'b1;
      #1;
      chk("hold_flush_drop", bus.instr_valid, 0);
      step();
      bus.flush = 1'b0;
      bus.instr_ready = 1'b0;
      wait_n = 2;
      #1;
      chk("reload_pc", bus.pc_value, 12'h0A0);
      chk("reload_idle_req", bus.mem_req, 0);
      step();
      chk("b3_req", bus.mem_req, 1);
      chk("b3_req_addr", bus.mem_addr, 12'h0A0);
      npulse = 0;
      wait_valid(n);
      chk("b3_latency", n, 12);
      chk("b3_opcode", bus.opcode, 8'h85);
      chk("b3_operand", bus.operand, 16'h1234);
      chk("b3_len", bus.instr_len, 3);
      chk("b3_addr", bus.instr_addr, 12'h0A0);
      chk("b3_pc", bus.pc_value, 12'h0A3);
      chk("b3_pulses", npulse, 3);

      // Flush on the second byte of a 2-byte instruction
      reload = 12'h0B0;
      wait_n = 0;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (!(bus.mem_req && bus.mem_addr == 12'h0B1) && n < 20);
      chk("fl_reach_b1", n, 3);
      chk("fl_ack", bus.mem_ack, 1);
      reload = 12'h0F0;
      bus.flush = 1'b1;
      #1;
      chk("fl_pc_en", bus.pc_enable, 0);
      chk("fl_valid", bus.instr_valid, 0);
      step();
      bus.flush = 1'b0;
      chk("fl_pc", bus.pc_value, 12'h0F0);
      chk("fl_idle_pc_en", bus.pc_enable, 0);
      chk("fl_idle_valid", bus.instr_valid, 0);
      step();
      chk("fl_next_req", bus.mem_req, 1);
      chk("fl_next_addr", bus.mem_addr, 12'h0F0);
      wait_valid(n);
      chk("fl_next_addr_out", bus.instr_addr, 12'h0F0);

      // Address wrap-around
      mem[12'h000] = 8'h77;
      reload = 12'hFFF;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      wait_valid(n);
      chk("wr_latency", n, 4);
      chk("wr_opcode", bus.opcode, 8'h40);
      chk("wr_addr", bus.instr_addr, 12'hFFF);
      chk("wr_operand", bus.operand, 16'h0077);
      chk("wr_len", bus.instr_len, 2);
      chk("wr_pc", bus.pc_value, 12'h001);

      // Mixed traffic checked by the scoreboard
      for (int i = 12'h100; i < 12'h200; i++) mem[i] = 8'($urandom);
      reload = 12'h100;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      for (int i = 0; i < 400; i++) begin
         bus.instr_ready = 1'($urandom_range(0, 1));
         wait_n = $urandom_range(0, 2);
         bus.flush = ($urandom_range(0, 15) == 0);
         reload = 12'h100 + AW'($urandom_range(0, 200));
         step();
      end
      bus.flush = 1'b0;
      bus.instr_ready = 1'b1;
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and instruction decode. Reads 1–3 instruction bytes from program memory at the address the program counter presents, steps the counter once per byte fetched, and hands the assembled instruction downstream over a valid/ready handshake. A `flush` input discards in-flight work after the counter has been reloaded for a jump or branch.

## Interface
- `ADDR_W`, 12: program address width; must match the program counter width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_value`  in  ADDR_W  current program counter value.
- `pc_enable`  out  1  one-cycle pulse that increments the program counter on the next edge.
- `mem_addr`  out  ADDR_W  program memory byte address.
- `mem_req`  out  1  read request; held high until `mem_ack`.
- `mem_ack`  in  1  read accepted; `mem_data` is valid in the same cycle.
- `mem_data`  in  8  read data.
- `flush`  in  1  synchronous discard; the counter is reloaded externally in the same cycle.
- `instr_valid`  out  1  instruction output valid.
- `instr_ready`  in  1  decode accepts the instruction.
- `opcode`  out  8  first instruction byte.
- `operand`  out  16  second byte in [7:0] and third byte in [15:8]; unused bytes are 0.
- `instr_len`  out  2  instruction length in bytes (1–3).
- `instr_addr`  out  ADDR_W  address of the opcode byte.

## Operation
- **Length decode:** from `opcode[7:6]`. 00 gives 1 byte, 01 gives 2 bytes, 1x gives 3 bytes.
- **States:** IDLE, FETCH, STEP, HOLD.
- **IDLE:** all strobes low. Moves to FETCH next cycle.
- **FETCH:**
  - `mem_req`=1 and `mem_addr`=`pc_value`, combinationally.
  - On byte 0, `instr_addr` is loaded from `pc_value`.
  - On `mem_ack`, `mem_data` is captured into byte slot k (opcode, operand[7:0], operand[15:8]) and the state moves to STEP.
  - On byte 0, `instr_len` is latched from the length decode and the operand register is cleared.
- **STEP:**
  - `pc_enable`=1 for exactly this cycle.
  - If bytes fetched < `instr_len`, return to FETCH; the counter is already incremented when FETCH samples it.
  - Otherwise go to HOLD.
- **HOLD:**
  - `instr_valid`=1; `opcode`, `operand`, `instr_len` and `instr_addr` are stable.
  - When `instr_valid`&&`instr_ready`, move to FETCH for the next opcode; there is no idle cycle.
- **Outputs:** registered, except `mem_req` and `mem_addr`, which are decoded from state.
- **Flush:**
  - Has priority over every transition, in every state.
  - Next state is IDLE and the byte count is cleared.
  - `pc_enable` and `instr_valid` are forced to 0 in the flush cycle.
  - A `mem_ack` coinciding with `flush` is ignored.
  - A HOLD instruction present in the flush cycle is dropped, even if `instr_ready`=1.
- **Wrap-around:**
  - Operand bytes follow `pc_value` wrapping at 2^ADDR_W−1 to 0; the block needs no special logic for this.
  - `instr_addr` keeps the opcode address.
- **Reset:**
  - Asynchronous.
  - State goes to IDLE; `pc_enable`, `mem_req`, `instr_valid` go to 0; `opcode`, `operand`, `instr_len`, `instr_addr` and `mem_addr` read 0.
  - Reset asserted mid-fetch abandons the request immediately.

## Timing
- **Zero-wait memory** (`mem_ack` tied high):
  - A 1-byte instruction is FETCH, STEP, HOLD: `instr_valid` rises 2 cycles after entering FETCH.
  - A 3-byte instruction takes 6 cycles.
- **Wait states:** each cycle of `mem_ack`=0 extends FETCH by one cycle.
- **Handshake:**
  - `mem_req` stays high and `mem_addr` stable until acknowledged.
  - `instr_valid` stays high and outputs stay stable until `instr_ready`.
- **Counter sequence:** exactly one `pc_enable` pulse per accepted byte, so `pc_value` points at the next opcode when HOLD is entered.
- **Throughput:** with `instr_ready` high and zero-wait memory, one 1-byte instruction every 3 cycles.

## Test plan
- **Reset:** assert `reset` mid-FETCH -> all outputs 0 in the same cycle; after release, one IDLE cycle then `mem_req`=1 at `mem_addr`=`pc_value`.
- **1-byte instruction:** memory at 0x000 holds 0x12, zero-wait -> `opcode`=0x12, `operand`=0, `instr_len`=1, `instr_addr`=0x000, a single `pc_enable` pulse, PC=1.
- **3-byte instruction with wait states:** 0x0A0 holds 0x85, 0x34, 0x12, with 2 wait cycles per byte -> `operand`=0x1234, `instr_len`=3, three `pc_enable` pulses, `instr_valid` rises 12 cycles after the first FETCH.
- **Back-pressure:** hold `instr_ready`=0 for 5 cycles in HOLD -> outputs stable, no `mem_req`, no `pc_enable`; on `instr_ready`=1, FETCH the next cycle.
- **Flush:** assert `flush` with `mem_ack`=1 on the second byte of a 2-byte instruction, reloading the PC to 0x0F0 -> byte ignored, no `pc_enable`, no `instr_valid`; the next fetch starts at `mem_addr`=0x0F0.
- **Wrap-around:** 0xFFF holds opcode 0x40 and 0x000 holds 0x77 -> `instr_addr`=0xFFF, `operand`=0x0077, PC=0x001.
